// File: rtl/mux_arbiter_pkg.sv
// mux_arbiter_pkg
//   Shared definitions for the 2:1 mux arbiter: FSM state encoding, owner
//   identifiers, select constants and the shared counter width helper.
//   Build option: MUX_ARBITER_DEADTIME_EN (consumed by mux_arbiter).
package mux_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    GUARD = 2'b01,
    OWN_A = 2'b10,
    OWN_B = 2'b11
  } state_e;

  typedef enum logic {
    OWNER_A = 1'b0,
    OWNER_B = 1'b1
  } owner_e;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  // One counter serves both the guard and hold timing, so it is sized for
  // whichever of the two needs more bits.
  function automatic int unsigned cnt_width(input int unsigned dead,
                                            input int unsigned hold);
    int unsigned wd;
    int unsigned wh;
    wd = $clog2(dead) + 1;
    wh = $clog2(hold) + 1;
    return (wd > wh) ? wd : wh;
  endfunction

endpackage

// File: rtl/mux_arbiter_cnt.sv
// mux_arbiter_cnt
//   Loadable saturating up/down counter. Load has priority; counting up stops
//   at limit_i, counting down stops at zero, so the count never wraps.
//   Ports:
//     clk, rst_n     clock, asynchronous active-low reset (count -> 0)
//     load_i         load load_val_i this cycle
//     load_val_i     value to load
//     up_i, down_i   increment / decrement request (mutually exclusive)
//     limit_i        terminal value for counting up
//     cnt_o          current count
module mux_arbiter_cnt #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             up_i,
  input  logic             down_i,
  input  logic [WIDTH-1:0] limit_i,
  output logic [WIDTH-1:0] cnt_o
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (up_i && (cnt_q < limit_i)) begin
      cnt_d = cnt_q + 1'b1;
    end else if (down_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/mux_arbiter.sv
// mux_arbiter
//   Round-robin arbiter for an external enabled 2:1 mux shared by requesters
//   A and B. With MUX_ARBITER_DEADTIME_EN defined, every new grant is
//   preceded by DEAD_CYCLES break-before-make cycles (e=0, s=target); without
//   it, grants and handoffs take effect on the same edge. An owner holding
//   the mux while the other side waits is released after MAX_HOLD cycles.
//   All outputs are registered.
//   Ports:
//     clk, rst_n     clock, asynchronous active-low reset
//     req_a, req_b   requests from A and B
//     s              mux select (0 = A, 1 = B)
//     e              mux enable
//     gnt_a, gnt_b   ownership indications
//     busy           FSM not idle
module mux_arbiter
  import mux_arbiter_pkg::*;
#(
  parameter int unsigned DEAD_CYCLES = 2,
  parameter int unsigned MAX_HOLD    = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req_a,
  input  logic req_b,
  output logic s,
  output logic e,
  output logic gnt_a,
  output logic gnt_b,
  output logic busy
);

  localparam int unsigned CNT_W = cnt_width(DEAD_CYCLES, MAX_HOLD);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);
`ifdef MUX_ARBITER_DEADTIME_EN
  localparam logic [CNT_W-1:0] GUARD_LOAD = CNT_W'(DEAD_CYCLES - 1);
`endif

  state_e state_q, state_d;
  owner_e last_q,  last_d;
`ifdef MUX_ARBITER_DEADTIME_EN
  owner_e tgt_q,   tgt_d;
  logic   go_guard;
  logic   tgt_req, tgt_oth_req;
`endif
  logic s_q, s_d;
  logic e_q, e_d;
  logic gnt_a_q, gnt_a_d;
  logic gnt_b_q, gnt_b_d;
  logic busy_q, busy_d;

  logic             cnt_load;
  logic [CNT_W-1:0] cnt_load_val;
  logic             cnt_up;
  logic             cnt_down;
  logic [CNT_W-1:0] cnt;

  owner_e pick;
  owner_e own_x;
  owner_e go_who;
  logic   go_own;
  logic   req_own, req_oth;

  mux_arbiter_cnt #(
    .WIDTH(CNT_W)
  ) u_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .load_i    (cnt_load),
    .load_val_i(cnt_load_val),
    .up_i      (cnt_up),
    .down_i    (cnt_down),
    .limit_i   (HOLD_LAST),
    .cnt_o     (cnt)
  );

  // State register, including the registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= OWNER_B;
`ifdef MUX_ARBITER_DEADTIME_EN
      tgt_q   <= OWNER_A;
`endif
      s_q     <= SEL_A;
      e_q     <= 1'b0;
      gnt_a_q <= 1'b0;
      gnt_b_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
`ifdef MUX_ARBITER_DEADTIME_EN
      tgt_q   <= tgt_d;
`endif
      s_q     <= s_d;
      e_q     <= e_d;
      gnt_a_q <= gnt_a_d;
      gnt_b_q <= gnt_b_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state logic. Each case arm only decides where to go (go_own /
  // go_guard + go_who); the common entry actions (select, counter load) are
  // applied once after the case.
  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    s_d          = s_q;
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_up       = 1'b0;
    cnt_down     = 1'b0;
    go_own       = 1'b0;
    go_who       = OWNER_A;
`ifdef MUX_ARBITER_DEADTIME_EN
    tgt_d        = tgt_q;
    go_guard     = 1'b0;
    tgt_req      = (tgt_q == OWNER_B) ? req_b : req_a;
    tgt_oth_req  = (tgt_q == OWNER_B) ? req_a : req_b;
`endif

    // Tie goes to whoever was not served last.
    if (req_a && req_b) begin
      pick = (last_q == OWNER_B) ? OWNER_A : OWNER_B;
    end else begin
      pick = req_a ? OWNER_A : OWNER_B;
    end

    own_x   = (state_q == OWN_B) ? OWNER_B : OWNER_A;
    req_own = (state_q == OWN_B) ? req_b : req_a;
    req_oth = (state_q == OWN_B) ? req_a : req_b;

    case (state_q)
      IDLE: begin
        if (req_a || req_b) begin
          go_who = pick;
`ifdef MUX_ARBITER_DEADTIME_EN
          go_guard = 1'b1;
`else
          go_own = 1'b1;
`endif
        end
      end
`ifdef MUX_ARBITER_DEADTIME_EN
      GUARD: begin
        if (cnt == '0) begin
          if (tgt_req) begin
            go_own = 1'b1;
            go_who = tgt_q;
          end else if (tgt_oth_req) begin
            go_guard = 1'b1;
            go_who   = (tgt_q == OWNER_B) ? OWNER_A : OWNER_B;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_down = 1'b1;
        end
      end
`endif
      OWN_A, OWN_B: begin
        if (!req_own || (req_oth && (cnt == HOLD_LAST))) begin
          last_d = own_x;
          if (req_oth) begin
            go_who = (own_x == OWNER_B) ? OWNER_A : OWNER_B;
`ifdef MUX_ARBITER_DEADTIME_EN
            go_guard = 1'b1;
`else
            go_own = 1'b1;
`endif
          end else begin
            state_d = IDLE;
          end
        end else if (req_oth) begin
          cnt_up = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (go_own) begin
      state_d      = (go_who == OWNER_B) ? OWN_B : OWN_A;
      cnt_load     = 1'b1;
      cnt_load_val = '0;
`ifndef MUX_ARBITER_DEADTIME_EN
      s_d          = (go_who == OWNER_B) ? SEL_B : SEL_A;
`endif
    end
`ifdef MUX_ARBITER_DEADTIME_EN
    if (go_guard) begin
      state_d      = GUARD;
      tgt_d        = go_who;
      s_d          = (go_who == OWNER_B) ? SEL_B : SEL_A;
      cnt_load     = 1'b1;
      cnt_load_val = GUARD_LOAD;
    end
`endif
  end

  // Outputs are decoded from the next state so they register in step with it.
  always_comb begin
    e_d     = (state_d == OWN_A) || (state_d == OWN_B);
    gnt_a_d = (state_d == OWN_A);
    gnt_b_d = (state_d == OWN_B);
    busy_d  = (state_d != IDLE);
  end

  assign s     = s_q;
  assign e     = e_q;
  assign gnt_a = gnt_a_q;
  assign gnt_b = gnt_b_q;
  assign busy  = busy_q;

endmodule
